// File: rtl/design1_wrapper.sv
// design1_wrapper
//   AXI4 (full) slave register bank that holds the MemorEDF configuration.
//   NUM_REGS 32-bit registers are grouped into lines of DATA_WIDTH/32 registers.
//   Each data beat reads or writes one whole line, and byte lane k maps to byte k
//   of that line. Only the low offset bits of an address are decoded. Upstream
//   logic places the block at BASE_ADDR.
//
// Ports
//   aclk_0, areset_0   clock, asynchronous active-high reset
//   s_axi_aw*          write address channel (INCR/FIXED; WRAP handled as INCR)
//   s_axi_w*           write data channel (wlast is not used to end the burst)
//   s_axi_b*           write response channel (always OKAY)
//   s_axi_ar*          read address channel
//   s_axi_r*           read data channel (always OKAY)
//   cfg_regs           flat register contents, reg i at [32i+31:32i]
//
// Handshake rule for every channel: a transfer occurs on a rising edge where
// valid and ready are both 1. All ready/valid outputs come from flops, so no
// input valid reaches an output ready through combinational logic. A source
// holds its payload stable while valid=1 and ready=0.
module design1_wrapper #(
    parameter int          DATA_WIDTH = 128,
    parameter int          ADDR_WIDTH = 32,
    parameter int          ID_WIDTH   = 4,
    parameter int          NUM_REGS   = 16,
    parameter logic [31:0] BASE_ADDR  = 32'hC0000000
) (
    input  logic                      aclk_0,
    input  logic                      areset_0,
    input  logic [ID_WIDTH-1:0]       s_axi_awid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                s_axi_awlen,
    input  logic [2:0]                s_axi_awsize,
    input  logic [1:0]                s_axi_awburst,
    input  logic                      s_axi_awvalid,
    output logic                      s_axi_awready,
    input  logic [DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                      s_axi_wlast,
    input  logic                      s_axi_wvalid,
    output logic                      s_axi_wready,
    output logic [ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                s_axi_bresp,
    output logic                      s_axi_bvalid,
    input  logic                      s_axi_bready,
    input  logic [ID_WIDTH-1:0]       s_axi_arid,
    input  logic [ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                s_axi_arlen,
    input  logic [2:0]                s_axi_arsize,
    input  logic [1:0]                s_axi_arburst,
    input  logic                      s_axi_arvalid,
    output logic                      s_axi_arready,
    output logic [ID_WIDTH-1:0]       s_axi_rid,
    output logic [DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                s_axi_rresp,
    output logic                      s_axi_rlast,
    output logic                      s_axi_rvalid,
    input  logic                      s_axi_rready,
    output logic [NUM_REGS*32-1:0]    cfg_regs
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);            // byte-in-line bits
    localparam int DEC_W = $clog2(NUM_REGS * 4);     // decoded offset bits
    localparam int LINES = (NUM_REGS * 4) / BYTES;
    localparam int LIW   = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int RW    = $clog2(NUM_REGS * 32);    // bit index into cfg_regs
    // The running burst offset is wider than the decoded window. An INCR burst
    // can then run past the last register without wrapping back onto reg 0,
    // and those beats land out of range.
    localparam int OFF_W = 16;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    w_state_t              w_state, w_next;
    r_state_t              r_state, r_next;

    logic [ID_WIDTH-1:0]   w_id;
    logic [7:0]            w_len, w_cnt;
    logic [2:0]            w_size;
    logic [1:0]            w_burst;
    logic [OFF_W-1:0]      w_off;

    logic [7:0]            r_len, r_cnt;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [OFF_W-1:0]      r_off;

    logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs;
    logic [OFF_W-1:0]      ar_off, r_off_nxt;

    logic                  unused_ok;
    assign unused_ok = ^{s_axi_wlast, s_axi_awaddr[ADDR_WIDTH-1:DEC_W],
                         s_axi_araddr[ADDR_WIDTH-1:DEC_W], BASE_ADDR};

    assign aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_hs  = s_axi_wvalid  & s_axi_wready;
    assign b_hs  = s_axi_bvalid  & s_axi_bready;
    assign ar_hs = s_axi_arvalid & s_axi_arready;
    assign r_hs  = s_axi_rvalid  & s_axi_rready;

    assign s_axi_bresp = 2'b00;
    assign s_axi_rresp = 2'b00;

    function automatic logic [OFF_W-1:0] step_off(input logic [OFF_W-1:0] off,
                                                  input logic [2:0] size,
                                                  input logic [1:0] burst);
        if (burst == 2'b00) return off;
        return off + (OFF_W'(1) << size);
    endfunction

    function automatic logic in_range(input logic [OFF_W-1:0] off);
        return (off >> LB) < OFF_W'(LINES);
    endfunction

    function automatic logic [RW-1:0] line_base(input logic [OFF_W-1:0] off);
        return RW'(off[LB +: LIW]) << $clog2(DATA_WIDTH);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] line_data(input logic [OFF_W-1:0] off);
        if (!in_range(off)) return '0;
        return cfg_regs[line_base(off) +: DATA_WIDTH];
    endfunction

    assign ar_off    = {{(OFF_W-DEC_W){1'b0}}, s_axi_araddr[DEC_W-1:0]};
    assign r_off_nxt = step_off(r_off, r_size, r_burst);

    // ---------------- write FSM ----------------
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && (w_cnt == w_len)) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk_0 or posedge areset_0) begin
        if (areset_0) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bid     <= '0;
            w_id          <= '0;
            w_len         <= '0;
            w_cnt         <= '0;
            w_size        <= '0;
            w_burst       <= '0;
            w_off         <= '0;
            cfg_regs      <= '0;
        end else begin
            w_state       <= w_next;
            // Ready/valid follow the next state, so they are valid the cycle the state is entered.
            s_axi_awready <= (w_next == W_IDLE);
            s_axi_wready  <= (w_next == W_DATA);
            s_axi_bvalid  <= (w_next == W_RESP);
            if (w_state == W_IDLE && aw_hs) begin
                w_id    <= s_axi_awid;
                w_len   <= s_axi_awlen;
                w_cnt   <= '0;
                w_size  <= s_axi_awsize;
                w_burst <= s_axi_awburst;
                w_off   <= {{(OFF_W-DEC_W){1'b0}}, s_axi_awaddr[DEC_W-1:0]};
            end
            if (w_state == W_DATA && w_hs) begin
                w_cnt <= w_cnt + 8'd1;
                w_off <= step_off(w_off, w_size, w_burst);
                s_axi_bid <= w_id;
                if (in_range(w_off)) begin
                    for (int k = 0; k < BYTES; k++) begin
                        if (s_axi_wstrb[k])
                            cfg_regs[line_base(w_off) + RW'(8*k) +: 8] <= s_axi_wdata[8*k +: 8];
                    end
                end
            end
        end
    end

    // ---------------- read FSM ----------------
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && s_axi_rlast) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Beat data is captured from cfg_regs at the edge before it is presented.
    // A write landing on that same edge is therefore not seen by the beat.
    always_ff @(posedge aclk_0 or posedge areset_0) begin
        if (areset_0) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rlast   <= 1'b0;
            s_axi_rid     <= '0;
            s_axi_rdata   <= '0;
            r_len         <= '0;
            r_cnt         <= '0;
            r_size        <= '0;
            r_burst       <= '0;
            r_off         <= '0;
        end else begin
            r_state       <= r_next;
            s_axi_arready <= (r_next == R_IDLE);
            s_axi_rvalid  <= (r_next == R_DATA);
            if (r_state == R_IDLE && ar_hs) begin
                s_axi_rid   <= s_axi_arid;
                s_axi_rdata <= line_data(ar_off);
                s_axi_rlast <= (s_axi_arlen == 8'd0);
                r_len       <= s_axi_arlen;
                r_cnt       <= '0;
                r_size      <= s_axi_arsize;
                r_burst     <= s_axi_arburst;
                r_off       <= ar_off;
            end else if (r_state == R_DATA && r_hs && !s_axi_rlast) begin
                s_axi_rdata <= line_data(r_off_nxt);
                s_axi_rlast <= ((r_cnt + 8'd1) == r_len);
                r_cnt       <= r_cnt + 8'd1;
                r_off       <= r_off_nxt;
            end
        end
    end

endmodule

// File: tb/tb_design1_wrapper.sv
// Directed testbench for design1_wrapper.
// The bench drives inputs 1 time unit after the rising edge and samples outputs
// at that same point.
module tb_design1_wrapper;

    localparam int DW = 128;
    localparam int AW = 32;
    localparam int IW = 4;
    localparam int NR = 16;

    logic               aclk_0 = 1'b0;
    logic               areset_0 = 1'b1;
    logic [IW-1:0]      s_axi_awid = '0;
    logic [AW-1:0]      s_axi_awaddr = '0;
    logic [7:0]         s_axi_awlen = '0;
    logic [2:0]         s_axi_awsize = '0;
    logic [1:0]         s_axi_awburst = '0;
    logic               s_axi_awvalid = 1'b0;
    logic               s_axi_awready;
    logic [DW-1:0]      s_axi_wdata = '0;
    logic [DW/8-1:0]    s_axi_wstrb = '0;
    logic               s_axi_wlast = 1'b0;
    logic               s_axi_wvalid = 1'b0;
    logic               s_axi_wready;
    logic [IW-1:0]      s_axi_bid;
    logic [1:0]         s_axi_bresp;
    logic               s_axi_bvalid;
    logic               s_axi_bready = 1'b0;
    logic [IW-1:0]      s_axi_arid = '0;
    logic [AW-1:0]      s_axi_araddr = '0;
    logic [7:0]         s_axi_arlen = '0;
    logic [2:0]         s_axi_arsize = '0;
    logic [1:0]         s_axi_arburst = '0;
    logic               s_axi_arvalid = 1'b0;
    logic               s_axi_arready;
    logic [IW-1:0]      s_axi_rid;
    logic [DW-1:0]      s_axi_rdata;
    logic [1:0]         s_axi_rresp;
    logic               s_axi_rlast;
    logic               s_axi_rvalid;
    logic               s_axi_rready = 1'b0;
    logic [NR*32-1:0]   cfg_regs;

    int tests_run = 0;
    int tests_failed = 0;

    design1_wrapper dut (
        .aclk_0(aclk_0), .areset_0(areset_0),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
        .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .cfg_regs(cfg_regs)
    );

    // ---------------- clock / watchdog ----------------
    always #5 aclk_0 = ~aclk_0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1);
    end

    function automatic logic [31:0] reg_at(input int i);
        return cfg_regs[32*i +: 32];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge aclk_0); #1;
    endtask

    task automatic aw_send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        while (s_axi_awready !== 1'b1 && n < 50) begin tick(); n++; end
        if (s_axi_awready !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL aw_timeout: awready=%b required 1", s_axi_awready);
        end
        tick();
        s_axi_awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [DW-1:0] data, input logic [DW/8-1:0] strb, input logic last);
        int n = 0;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1'b1;
        while (s_axi_wready !== 1'b1 && n < 50) begin tick(); n++; end
        if (s_axi_wready !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL w_timeout: wready=%b required 1", s_axi_wready);
        end
        tick();
        s_axi_wvalid = 1'b0;
    endtask

    task automatic b_recv(output logic [IW-1:0] id, output logic [1:0] resp);
        int n = 0;
        s_axi_bready = 1'b1;
        while (s_axi_bvalid !== 1'b1 && n < 50) begin tick(); n++; end
        if (s_axi_bvalid !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL b_timeout: bvalid=%b required 1", s_axi_bvalid);
        end
        id = s_axi_bid; resp = s_axi_bresp;
        tick();
        s_axi_bready = 1'b0;
    endtask

    task automatic ar_send(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                           input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
        int n = 0;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        while (s_axi_arready !== 1'b1 && n < 50) begin tick(); n++; end
        if (s_axi_arready !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL ar_timeout: arready=%b required 1", s_axi_arready);
        end
        tick();
        s_axi_arvalid = 1'b0;
    endtask

    task automatic r_recv(output logic [DW-1:0] data, output logic last,
                          output logic [1:0] resp, output logic [IW-1:0] id);
        int n = 0;
        s_axi_rready = 1'b1;
        while (s_axi_rvalid !== 1'b1 && n < 50) begin tick(); n++; end
        if (s_axi_rvalid !== 1'b1) begin
            tests_run++; tests_failed++;
            $display("FAIL r_timeout: rvalid=%b required 1", s_axi_rvalid);
        end
        data = s_axi_rdata; last = s_axi_rlast; resp = s_axi_rresp; id = s_axi_rid;
        tick();
        s_axi_rready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        areset_0 = 1'b1;
        repeat (3) tick();
        tests_run++;
        if (cfg_regs !== '0) begin tests_failed++; $display("FAIL reset_regs: got %h required 0", cfg_regs); end
        tests_run++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_handshakes: aw/w/b/ar/r=%b required 00000",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid});
        end
        tests_run++;
        if ({s_axi_bresp, s_axi_rresp, s_axi_rdata} !== '0) begin
            tests_failed++; $display("FAIL reset_resp_rdata: rdata=%h bresp=%b rresp=%b required 0",
                                     s_axi_rdata, s_axi_bresp, s_axi_rresp);
        end
        areset_0 = 1'b0;
        tick();
        tests_run++;
        if ({s_axi_awready, s_axi_arready} !== 2'b11) begin
            tests_failed++; $display("FAIL idle_ready: aw/ar=%b required 11", {s_axi_awready, s_axi_arready});
        end
    endtask

    task automatic test_single_write();
        logic [IW-1:0] id; logic [1:0] resp;
        aw_send(4'h3, 32'hC000_0000, 8'd0, 3'd4, 2'b01);
        w_send({96'h0, 32'h89AB_CDEF}, 16'h000F, 1'b1);
        tests_run++;
        if (reg_at(0) !== 32'h89AB_CDEF) begin tests_failed++; $display("FAIL single_reg0: got %h required 89abcdef", reg_at(0)); end
        tests_run++;
        if ({reg_at(1), reg_at(2), reg_at(3)} !== 96'h0) begin
            tests_failed++; $display("FAIL single_reg1_3: got %h required 0", {reg_at(1), reg_at(2), reg_at(3)});
        end
        b_recv(id, resp);
        tests_run++;
        if ({id, resp} !== {4'h3, 2'b00}) begin tests_failed++; $display("FAIL single_b: bid=%h bresp=%b required 3/00", id, resp); end
        tests_run++;
        if (s_axi_bvalid !== 1'b0) begin tests_failed++; $display("FAIL single_b_once: bvalid=%b required 0", s_axi_bvalid); end
    endtask

    task automatic test_reg1_write_read();
        logic [IW-1:0] id; logic [1:0] resp; logic [DW-1:0] data; logic last;
        aw_send(4'h5, 32'hC000_0004, 8'd0, 3'd2, 2'b01);
        w_send({64'h0, 32'h89AB_CDEF, 32'h0}, 16'h00F0, 1'b1);
        b_recv(id, resp);
        tests_run++;
        if ({reg_at(1), reg_at(0)} !== 64'h89AB_CDEF_89AB_CDEF) begin
            tests_failed++; $display("FAIL reg1_write: reg1/reg0=%h required 89abcdef89abcdef", {reg_at(1), reg_at(0)});
        end
        ar_send(4'h9, 32'hC000_0000, 8'd0, 3'd4, 2'b01);
        r_recv(data, last, resp, id);
        tests_run++;
        if (data !== 128'h0000_0000_0000_0000_89AB_CDEF_89AB_CDEF) begin
            tests_failed++; $display("FAIL read_line0: rdata=%h required 000000000000000089abcdef89abcdef", data);
        end
        tests_run++;
        if ({last, resp, id} !== {1'b1, 2'b00, 4'h9}) begin
            tests_failed++; $display("FAIL read_single_ctrl: rlast=%b rresp=%b rid=%h required 1/00/9", last, resp, id);
        end
    endtask

    task automatic test_long_incr();
        logic [IW-1:0] id; logic [1:0] resp; logic early_b = 1'b0;
        logic [31:0] exp;
        aw_send(4'hA, 32'hC000_0000, 8'd128, 3'd4, 2'b01);
        for (int n = 0; n < 129; n++) begin
            if (s_axi_bvalid === 1'b1) early_b = 1'b1;
            w_send({4{n[31:0]}}, 16'hFFFF, (n == 128));
        end
        tests_run++;
        if (early_b !== 1'b0) begin tests_failed++; $display("FAIL long_early_b: bvalid seen=%b required 0", early_b); end
        for (int i = 0; i < NR; i++) begin
            exp = i / 4;
            tests_run++;
            if (reg_at(i) !== exp) begin tests_failed++; $display("FAIL long_reg%0d: got %h required %h", i, reg_at(i), exp); end
        end
        b_recv(id, resp);
        tests_run++;
        if ({id, resp} !== {4'hA, 2'b00}) begin tests_failed++; $display("FAIL long_b: bid=%h bresp=%b required a/00", id, resp); end
        repeat (3) tick();
        tests_run++;
        if (s_axi_bvalid !== 1'b0) begin tests_failed++; $display("FAIL long_b_once: bvalid=%b required 0", s_axi_bvalid); end
    endtask

    task automatic test_read_burst_stall();
        logic [IW-1:0] id; logic [1:0] resp; logic [DW-1:0] data, hold; logic last, stable;
        logic [DW-1:0] exp;
        ar_send(4'h6, 32'hC000_0000, 8'd3, 3'd4, 2'b01);
        for (int b = 0; b < 4; b++) begin
            exp = {4{b[31:0]}};
            if (b == 1) begin
                hold = s_axi_rdata; stable = s_axi_rvalid;
                repeat (3) begin
                    tick();
                    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== hold) stable = 1'b0;
                end
                tests_run++;
                if (stable !== 1'b1 || hold !== exp) begin
                    tests_failed++; $display("FAIL read_stall_hold: stable=%b held=%h required 1/%h", stable, hold, exp);
                end
            end
            r_recv(data, last, resp, id);
            tests_run++;
            if (data !== exp) begin tests_failed++; $display("FAIL read_beat%0d_data: got %h required %h", b, data, exp); end
            tests_run++;
            if ({last, resp, id} !== {(b == 3), 2'b00, 4'h6}) begin
                tests_failed++; $display("FAIL read_beat%0d_ctrl: rlast=%b rresp=%b rid=%h required %b/00/6", b, last, resp, id, (b == 3));
            end
        end
        tests_run++;
        if (s_axi_rvalid !== 1'b0) begin tests_failed++; $display("FAIL read_end: rvalid=%b required 0", s_axi_rvalid); end
    endtask

    task automatic test_fixed_write();
        logic [IW-1:0] id; logic [1:0] resp;
        aw_send(4'h2, 32'hC000_0010, 8'd2, 3'd4, 2'b00);
        for (int n = 1; n <= 3; n++) w_send({4{n[31:0]}}, 16'hFFFF, (n == 3));
        b_recv(id, resp);
        tests_run++;
        if ({reg_at(7), reg_at(6), reg_at(5), reg_at(4)} !== {4{32'd3}}) begin
            tests_failed++; $display("FAIL fixed_regs4_7: got %h required all 3", {reg_at(7), reg_at(6), reg_at(5), reg_at(4)});
        end
        tests_run++;
        if ({reg_at(8), reg_at(0)} !== {32'd2, 32'd0}) begin
            tests_failed++; $display("FAIL fixed_neighbours: reg8/reg0=%h required 0000000200000000", {reg_at(8), reg_at(0)});
        end
        tests_run++;
        if ({id, resp} !== {4'h2, 2'b00}) begin tests_failed++; $display("FAIL fixed_b: bid=%h bresp=%b required 2/00", id, resp); end
    endtask

    task automatic test_reset_midburst();
        logic [IW-1:0] id; logic [1:0] resp; logic saw_b = 1'b0;
        aw_send(4'h7, 32'hC000_0000, 8'd7, 3'd4, 2'b01);
        w_send({4{32'hA5A5_A5A5}}, 16'hFFFF, 1'b0);
        w_send({4{32'h5A5A_5A5A}}, 16'hFFFF, 1'b0);
        tests_run++;
        if ({reg_at(4), reg_at(0)} !== {32'h5A5A_5A5A, 32'hA5A5_A5A5}) begin
            tests_failed++; $display("FAIL midburst_partial: reg4/reg0=%h required 5a5a5a5aa5a5a5a5", {reg_at(4), reg_at(0)});
        end
        areset_0 = 1'b1;
        #1;
        tests_run++;
        if (cfg_regs !== '0) begin tests_failed++; $display("FAIL midburst_regs: got %h required 0", cfg_regs); end
        repeat (2) begin tick(); if (s_axi_bvalid !== 1'b0) saw_b = 1'b1; end
        areset_0 = 1'b0;
        repeat (6) begin tick(); if (s_axi_bvalid !== 1'b0) saw_b = 1'b1; end
        tests_run++;
        if (saw_b !== 1'b0) begin tests_failed++; $display("FAIL midburst_no_b: bvalid seen=%b required 0", saw_b); end
        aw_send(4'hC, 32'hC000_0008, 8'd0, 3'd2, 2'b01);
        w_send({32'h0, 32'h1234_5678, 64'h0}, 16'h0F00, 1'b1);
        b_recv(id, resp);
        tests_run++;
        if (reg_at(2) !== 32'h1234_5678) begin tests_failed++; $display("FAIL after_reset_reg2: got %h required 12345678", reg_at(2)); end
        tests_run++;
        if ({id, resp} !== {4'hC, 2'b00}) begin tests_failed++; $display("FAIL after_reset_b: bid=%h bresp=%b required c/00", id, resp); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_reg1_write_read();
        test_long_incr();
        test_read_burst_stall();
        test_fixed_write();
        test_reset_midburst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/design1_wrapper.md
Name: design1_wrapper

Overview:
- Top-level wrapper for the MemorEDF configuration port.
- Exposes an AXI4 (full) slave register bank of 32-bit configuration registers, mapped at base 0xC0000000 (system address decode is upstream).
- Register contents drive the MemorEDF scheduler as a flat output bus.
- Accepts INCR/FIXED bursts up to 256 beats on a 128-bit data bus.

Parameters:
- DATA_WIDTH, 128, AXI data bus width in bits.
- ADDR_WIDTH, 32, AXI address width.
- ID_WIDTH, 4, AXI ID width.
- NUM_REGS, 16, number of 32-bit configuration registers (multiple of 4).
- BASE_ADDR, 32'hC0000000, documentation only; slave decodes only the low offset bits.

Ports:
- aclk_0  in  1  system clock, all logic on rising edge.
- areset_0  in  1  asynchronous, active-high reset.
- s_axi_awid/awaddr/awlen/awsize/awburst  in  ID_WIDTH/ADDR_WIDTH/8/3/2  write address channel.
- s_axi_awvalid  in  1; s_axi_awready  out  1.
- s_axi_wdata/wstrb/wlast  in  DATA_WIDTH/DATA_WIDTH/8/1  write data channel.
- s_axi_wvalid  in  1; s_axi_wready  out  1.
- s_axi_bid/bresp  out  ID_WIDTH/2; s_axi_bvalid  out  1; s_axi_bready  in  1.
- s_axi_arid/araddr/arlen/arsize/arburst  in  same widths as AW; s_axi_arvalid  in  1; s_axi_arready  out  1.
- s_axi_rid/rdata/rresp/rlast  out  ID_WIDTH/DATA_WIDTH/2/1; s_axi_rvalid  out  1; s_axi_rready  in  1.
- cfg_regs  out  NUM_REGS*32  register contents, reg i at bits [32i+31:32i].

Behaviour:
- Reset (async assert, sync release):
  - all registers 0.
  - all READY/VALID outputs 0.
  - bresp/rresp 0, rdata 0.
  - both FSMs to IDLE.
- Reset mid-burst aborts the transaction. No response is issued for the aborted transaction.
- Register map:
  - reg i at byte offset 4*i.
  - decode uses addr[log2(NUM_REGS*4)-1:2]; upper address bits ignored.
- Beat mapping:
  - beat address aligned down to 16 bytes selects a line of 4 registers.
  - byte lane k of wdata/rdata maps to byte k of that line.
- Write FSM, IDLE -> WDATA -> WRESP -> IDLE:
  - IDLE: awready=1; on AW handshake latch id/addr/len/size/burst, go to WDATA.
  - WDATA: wready=1. Each W handshake writes only bytes with wstrb=1; the update is visible on cfg_regs the next cycle.
  - Address step: INCR adds 2^awsize after every beat; FIXED keeps the address; WRAP is treated as INCR.
  - Leave WDATA when the beat counter reaches awlen (wlast is ignored for termination).
  - WRESP: bvalid=1, bid=latched id, bresp=OKAY; hold until bready, then go to IDLE.
- Read FSM, IDLE -> RDATA -> IDLE:
  - IDLE: arready=1; on AR handshake latch fields and go to RDATA.
  - RDATA: rvalid=1, rid=latched id, rresp=OKAY, rdata=current line.
  - rlast=1 on beat arlen. Hold beat data until rready; advance the address as for writes.
  - Return to IDLE after the last handshake.
- Out-of-range beats (register index >= NUM_REGS):
  - writes discarded, reads return 0.
  - response still OKAY; the burst still completes with the full beat count.
- Concurrency:
  - read and write FSMs are independent.
  - a read beat in the same cycle as a write to the same register returns the pre-write value.
- One outstanding transaction per channel. No interleaving; no back-pressure beyond ready deassertion outside IDLE/WDATA.
- Combinational paths: none from input VALID to output READY; all outputs registered.

Test Plan:
- Single-beat write to 0xC0000000:
  - Stimulus: size 16B, len 0, wdata[31:0]=0x89ABCDEF, wstrb=0x000F.
  - Response: reg0=0x89ABCDEF, regs1-3 unchanged (0); one B beat OKAY, bid echoed.
- Write to 0xC0000004:
  - Stimulus: wdata[63:32]=0x89ABCDEF, wstrb=0x00F0.
  - Response: reg1=0x89ABCDEF, reg0 unchanged.
  - Read 0xC0000000 len 0 returns rdata[63:0]=0x89ABCDEF_89ABCDEF, rlast=1, OKAY.
- Long INCR write, len 128 (129 beats) from 0xC0000000:
  - Stimulus: beat n data = {4{n}}, full strobes.
  - Response: regs 0-15 = beats 0-3 per lane; beats 4-128 discarded; exactly one B OKAY after the 129th beat.
- Read burst len 3:
  - Response: 4 beats with register lines 0-3, rlast only on beat 4.
  - With rready low for 3 cycles on beat 2, rdata and rvalid hold stable.
- FIXED write, len 2, to 0xC0000010:
  - Stimulus: data 1, 2, 3 with full strobes.
  - Response: reg4-7 end at value 3.
- Reset mid-burst:
  - Stimulus: assert areset_0 after 2 of 8 write beats.
  - Response: all regs 0, bvalid never asserted; next AW is accepted normally.
